kpn_fifo_channel: RTL

Bounded FIFO channel linking two Kahn-process-network nodes: the responder end of the `rd`/`wr` strobe protocol that process modules (adder, subtractor, multiplier, …) drive. A producer node's `wr` strobe and 16-bit result are accepted into storage. A consumer node's `rd` strobe is answered with the oldest token, in order. KPN blocking semantics are enforced:
- A read on an empty channel or a write on a full channel is refused, never corrupts data, and is flagged.

---
 rtl/kpn_pkg.sv | 25 ++
 rtl/kpn_fifo_mem.sv | 28 ++
 rtl/kpn_fifo_channel.sv | 129 ++++++++++++
 3 files changed

// File: rtl/kpn_pkg.sv
// Shared definitions for KPN process nodes and the channels that connect them.
package kpn_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] kpn_token_t;

  typedef enum logic [1:0] {
    CH_EMPTY   = 2'd0,
    CH_PARTIAL = 2'd1,
    CH_FULL    = 2'd2
  } chan_state_t;

  // Occupancy class of a channel holding cnt tokens out of depth.
  function automatic chan_state_t chan_state(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return CH_EMPTY;
    end
    if (cnt >= depth) begin
      return CH_FULL;
    end
    return CH_PARTIAL;
  endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// Token storage for a KPN channel: one synchronous write port, one asynchronous
// read port. Contents are not reset; validity is tracked by the channel pointers.
module kpn_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read sees pre-edge contents, so a same-cycle write to the slot being read
  // (full channel, rd+wr) returns the old token.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded KPN channel: accepts producer wr strobes, answers consumer rd strobes
// in order, refuses reads when empty / writes when full and flags them stickily.
//
//   state      | meaning
//   CH_EMPTY   | count == 0, reads refused
//   CH_PARTIAL | 0 < count < DEPTH, reads and writes accepted
//   CH_FULL    | count == DEPTH, writes accepted only alongside a read
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = kpn_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [DATA_W-1:0] data_out_q,  data_out_d;
  logic              rd_valid_q,  rd_valid_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;

  chan_state_t       state;
  logic              full_w;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  kpn_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state   = chan_state(32'(count_q), 32'(CNT_DEPTH));
    full_w  = (state == CH_FULL);
    empty_w = (state == CH_EMPTY);
    // A full channel can still take a write when a read frees a slot in the same
    // cycle; an empty channel never bypasses a write straight to the reader.
    wr_acc  = wr && (!full_w || rd);
    rd_acc  = rd && !empty_w;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end else if (wr) begin
      overflow_d = 1'b1;
    end

    if (rd_acc) begin
      rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      data_out_d = mem_rdata;
      rd_valid_d = 1'b1;
    end else if (rd) begin
      underflow_d = 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
